fir_tap_mac: RTL

- Consumes the parallel tap window (newest sample at index 0) produced by the sample shift register.
- On each start request it snapshots the window and computes one FIR output y = sum(tap[i]*coef[i]).
- It uses a single time-shared multiplier-accumulator, one tap per clock.
- It returns the result with a one-cycle valid pulse to the downstream output stage.

---
 rtl/fir_tap_mac.sv | 86 ++++++++
 1 files changed

// File: rtl/fir_tap_mac.sv
// Time-shared FIR tap MAC: snapshots the tap window on start and accumulates
// one tap*coef product per clock, then emits the sum with a one-cycle valid.
module fir_tap_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataIn,
  input  logic [NUM_REGS-1:0][COEF_WIDTH-1:0]  coefIn,
  output logic                                 busy,
  output logic [ACC_WIDTH-1:0]                 yOut,
  output logic                                 yValid,
  output logic                                 startDropped
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

  typedef enum logic {IDLE, MAC} state_t;

  state_t                               state, state_next;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  win;
  logic [ACC_WIDTH-1:0]                 acc;
  logic signed [PROD_W-1:0]             prod;
  logic [ACC_WIDTH-1:0]                 acc_sum;
  logic                                 load;
  logic                                 last;

  assign prod    = $signed(win[idx]) * $signed(coefIn[idx]);
  assign acc_sum = acc + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
  assign busy    = (state == MAC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = (idx == IDX_W'(NUM_REGS - 1));
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = MAC;
      end
      MAC: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      win          <= '0;
      acc          <= '0;
      yOut         <= '0;
      yValid       <= 1'b0;
      startDropped <= 1'b0;
    end else begin
      yValid       <= 1'b0;
      startDropped <= busy & start;
      if (load) begin
        win <= pDataIn;
        acc <= '0;
        idx <= '0;
      end else if (busy) begin
        acc <= acc_sum;
        if (last) begin
          // final tap bypasses acc so the result lands on the same edge
          yOut   <= acc_sum;
          yValid <= 1'b1;
          idx    <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
